dlx_decode_stage: RTL and testbench
===================================

# dlx_decode_stage

Parametrised DLX instruction-decode stage between fetch and execute. It decodes one 32-bit DLX instruction per accepted handshake into ALU-op, register-index, immediate and PC-control fields. Results are queued in a DEPTH-entry output FIFO with valid/ready on both sides. Beyond the plain decoder it adds an XLEN-generic datapath, PC tag passthrough, an illegal-instruction flag and pipeline flush.

## Interface
- XLEN, 32, datapath/immediate/PC width; must be ≥ 32
- DEPTH, 2, output FIFO entries; must be ≥ 1
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all queued entries and any same-cycle input
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage accepts; transfer when in_valid && in_ready
- in_instr  in  32  instruction word
- in_pc  in  XLEN  PC of the instruction
- out_valid  out  1  FIFO head valid
- out_ready  in  1  execute consumes; pop when out_valid && out_ready
- out_pc  out  XLEN  carried PC
- out_alu_op  out  5  ALU op code
- out_rs1, out_rs2, out_rd  out  5 each  register indices
- out_imm  out  XLEN  extended immediate
- out_imm_sel  out  1  ALU B operand is out_imm
- out_pc_alu  out  1  ALU A operand is PC
- out_pc_cmd, out_pc_val  out  2 each  PC-unit command/source
- out_load, out_store  out  1 each  memory read/write
- out_illegal  out  1  undefined opcode/funct

## Operation
- Decode is combinational on in_instr. The decoded entry, with in_pc, is pushed on transfer.
- S = 16-bit sign-extend to XLEN, Z = zero-extend.
- **R-type (opcode 0x00):**
  - rs1 = [25:21], rs2 = [20:16], rd = [15:11], imm = 0, imm_sel = 0.
  - funct→op: 0x20→1, 0x22→2, 0x24→3, 0x25→4, 0x26→5, 0x04→6, 0x06→7, 0x28→10, 0x2c→11, 0x2a→12, 0x29→13, 0x07→14.
  - Any other funct: illegal = 1, op = 0.
- **J-type (0x02 J, 0x03 JAL):**
  - rs1 = rs2 = 0, pc_cmd = 10, pc_alu = 1, pc_val = 01, imm_sel = 0.
  - imm = 26-bit sign-extend.
  - JAL: op = 15, rd = 31. J: op = 0, rd = 0.
- **I-type defaults:**
  - rs1 = [25:21], rs2 = rd = [20:16], imm_sel = 1.
  - pc_cmd = pc_val = 00, load = store = 0.
- **I-type opcode→op/extension:**
  - 0x08 1 S, 0x0a 2 S, 0x0c 3 Z, 0x0d 4 Z, 0x0e 5 Z.
  - 0x14 6 Z, 0x16 7 Z, 0x17 14 Z, 0x18 10 S, 0x1c 11 S, 0x1a 12 S, 0x19 13 S.
  - 0x0f 0 Z (LHI).
  - 0x23 1 S, load = 1.
  - 0x2b 1 S, store = 1, rd = 0.
  - 0x04 16 S, pc_cmd = 10.
  - 0x05 17 S, pc_cmd = 10, rd = 0.
  - 0x13 15 Z, rd = 31, pc_cmd = pc_val = 11.
  - 0x12 0 Z, rd = 0, pc_cmd = pc_val = 11.
- **Other opcodes:** illegal = 1 and every other field 0. An illegal entry is still queued; execute traps on it.
- **FIFO:** circular buffer with wrap-around read/write pointers and a count 0..DEPTH.
- in_ready = !reset && count < DEPTH. Ready does not depend on out_ready; there is no combinational path in→out.
- Push and pop in the same cycle leave count unchanged.
- out_valid = count ≠ 0. All payload outputs are forced to 0 when out_valid = 0.
- **flush:**
  - Next cycle count = 0 and pointers = 0.
  - Any push or pop in the flush cycle is ignored.
  - in_ready stays as computed, so a handshake can complete during flush, but that input is dropped.

## Timing
- Reset: all outputs 0 while reset is high; FIFO pointers and count are cleared. After reset deasserts, in_ready = 1 and out_valid = 0.
- Latency: an instruction accepted at edge N drives out_valid = 1 from edge N onward (visible in cycle N+1) if the FIFO was empty.
- Throughput: 1 instruction per cycle while out_ready = 1.
- Full FIFO: in_ready = 0; the head holds stable until popped.
- Reset or flush mid-burst: everything is lost, and the payload goes to 0 in the next cycle.
- Reset has priority over flush.

## Test plan
- Reset, then push 0x00221820 (ADD r3,r1,r2) with out_ready = 1 → next cycle out_valid = 1, op = 1, rs1 = 1, rs2 = 2, rd = 3, imm_sel = 0, illegal = 0.
- Push 0x2022FFFF (ADDI r2,r1,-1), XLEN = 64 → op = 1, rd = 2, imm = 0xFFFF_FFFF_FFFF_FFFF, imm_sel = 1.
- Push 0x0FFFFFFC (JAL −4), in_pc = 0x100 → op = 15, rd = 31, pc_cmd = 10, pc_val = 01, pc_alu = 1, imm = 0xFFFFFFFC, out_pc = 0x100.
- Push opcode 0x3F and R-type funct 0x3F → out_illegal = 1 with all other fields 0; SW 0xAC220008 → store = 1, rd = 0, imm = 8.
- DEPTH = 2, out_ready = 0, push 3 instructions → in_ready drops after 2. Raise out_ready → entries emerge in order, third accepted, no loss or duplication.
- Fill 2 entries, assert flush together with in_valid → next cycle out_valid = 0, count 0, and the flushed-cycle input never appears.

Source files
------------

// File: rtl/dlx_decode_stage.sv
// DLX decode stage: combinational decode of one instruction per handshake into a DEPTH-entry FIFO.
// Latency: an entry accepted at edge N is at the head from edge N when the FIFO was empty.
// Backpressure: in_ready = !reset && count < DEPTH, independent of out_ready; payload is zero when empty.
module dlx_decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_alu_op,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic            out_imm_sel,
  output logic            out_pc_alu,
  output logic [1:0]      out_pc_cmd,
  output logic [1:0]      out_pc_val,
  output logic            out_load,
  output logic            out_store,
  output logic            out_illegal
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      alu_op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            imm_sel;
    logic            pc_alu;
    logic [1:0]      pc_cmd;
    logic [1:0]      pc_val;
    logic            load;
    logic            store;
    logic            illegal;
  } entry_t;

  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic [XLEN-1:0] sext;
  logic [XLEN-1:0] zext;
  logic [XLEN-1:0] jext;
  logic            legal;
  entry_t          dec;

  assign opcode = in_instr[31:26];
  assign funct  = in_instr[5:0];
  assign sext   = {{(XLEN-16){in_instr[15]}}, in_instr[15:0]};
  assign zext   = {{(XLEN-16){1'b0}}, in_instr[15:0]};
  assign jext   = {{(XLEN-26){in_instr[25]}}, in_instr[25:0]};

  // Decode the incoming instruction; any undefined encoding collapses to a bare illegal entry.
  always_comb begin
    dec   = '0;
    legal = 1'b1;
    case (opcode)
      6'h00: begin
        dec.rs1 = in_instr[25:21];
        dec.rs2 = in_instr[20:16];
        dec.rd  = in_instr[15:11];
        case (funct)
          6'h20: dec.alu_op = 5'd1;
          6'h22: dec.alu_op = 5'd2;
          6'h24: dec.alu_op = 5'd3;
          6'h25: dec.alu_op = 5'd4;
          6'h26: dec.alu_op = 5'd5;
          6'h04: dec.alu_op = 5'd6;
          6'h06: dec.alu_op = 5'd7;
          6'h28: dec.alu_op = 5'd10;
          6'h2c: dec.alu_op = 5'd11;
          6'h2a: dec.alu_op = 5'd12;
          6'h29: dec.alu_op = 5'd13;
          6'h07: dec.alu_op = 5'd14;
          default: legal = 1'b0;
        endcase
      end
      6'h02, 6'h03: begin
        dec.pc_cmd = 2'b10;
        dec.pc_alu = 1'b1;
        dec.pc_val = 2'b01;
        dec.imm    = jext;
        if (opcode == 6'h03) begin
          dec.alu_op = 5'd15;
          dec.rd     = 5'd31;
        end
      end
      default: begin
        dec.rs1     = in_instr[25:21];
        dec.rs2     = in_instr[20:16];
        dec.rd      = in_instr[20:16];
        dec.imm_sel = 1'b1;
        case (opcode)
          6'h08: begin dec.alu_op = 5'd1;  dec.imm = sext; end
          6'h0a: begin dec.alu_op = 5'd2;  dec.imm = sext; end
          6'h0c: begin dec.alu_op = 5'd3;  dec.imm = zext; end
          6'h0d: begin dec.alu_op = 5'd4;  dec.imm = zext; end
          6'h0e: begin dec.alu_op = 5'd5;  dec.imm = zext; end
          6'h14: begin dec.alu_op = 5'd6;  dec.imm = zext; end
          6'h16: begin dec.alu_op = 5'd7;  dec.imm = zext; end
          6'h17: begin dec.alu_op = 5'd14; dec.imm = zext; end
          6'h18: begin dec.alu_op = 5'd10; dec.imm = sext; end
          6'h1c: begin dec.alu_op = 5'd11; dec.imm = sext; end
          6'h1a: begin dec.alu_op = 5'd12; dec.imm = sext; end
          6'h19: begin dec.alu_op = 5'd13; dec.imm = sext; end
          6'h0f: begin dec.alu_op = 5'd0;  dec.imm = zext; end
          6'h23: begin dec.alu_op = 5'd1;  dec.imm = sext; dec.load = 1'b1; end
          6'h2b: begin dec.alu_op = 5'd1;  dec.imm = sext; dec.store = 1'b1; dec.rd = 5'd0; end
          6'h04: begin dec.alu_op = 5'd16; dec.imm = sext; dec.pc_cmd = 2'b10; end
          6'h05: begin dec.alu_op = 5'd17; dec.imm = sext; dec.pc_cmd = 2'b10; dec.rd = 5'd0; end
          6'h13: begin
            dec.alu_op = 5'd15; dec.imm = zext; dec.rd = 5'd31;
            dec.pc_cmd = 2'b11; dec.pc_val = 2'b11;
          end
          6'h12: begin
            dec.alu_op = 5'd0; dec.imm = zext; dec.rd = 5'd0;
            dec.pc_cmd = 2'b11; dec.pc_val = 2'b11;
          end
          default: legal = 1'b0;
        endcase
      end
    endcase
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
    dec.pc = in_pc;
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        mem_q [DEPTH];
  entry_t        head;
  logic          push, pop;

  assign in_ready  = !reset && (count_q < CW'(DEPTH));
  assign out_valid = !reset && (count_q != '0);
  // A flush-cycle handshake still completes on the wires but never touches the queue.
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Advance pointers and occupancy; flush returns everything to the empty state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // FIFO control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only observable through the valid-gated head.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dec;
  end

  assign head = out_valid ? mem_q[rd_ptr_q] : '0;

  assign out_pc      = head.pc;
  assign out_alu_op  = head.alu_op;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_rd      = head.rd;
  assign out_imm     = head.imm;
  assign out_imm_sel = head.imm_sel;
  assign out_pc_alu  = head.pc_alu;
  assign out_pc_cmd  = head.pc_cmd;
  assign out_pc_val  = head.pc_val;
  assign out_load    = head.load;
  assign out_store   = head.store;
  assign out_illegal = head.illegal;

endmodule

// File: tb/tb_dlx_decode_stage.sv
// Directed bench for dlx_decode_stage at XLEN=64, DEPTH=2.
// Inputs change and outputs are sampled on the falling edge.
// Expected entries are hand-decoded constants.
module tb_dlx_decode_stage;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc, out_pc, out_imm;
  logic [4:0]      out_alu_op, out_rs1, out_rs2, out_rd;
  logic            out_imm_sel, out_pc_alu, out_load, out_store, out_illegal;
  logic [1:0]      out_pc_cmd, out_pc_val;

  int checks = 0;
  int failures = 0;

  dlx_decode_stage #(.XLEN(XLEN), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_alu_op(out_alu_op), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_imm_sel(out_imm_sel), .out_pc_alu(out_pc_alu),
    .out_pc_cmd(out_pc_cmd), .out_pc_val(out_pc_val),
    .out_load(out_load), .out_store(out_store), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  logic [157:0] obs_vec;
  assign obs_vec = {out_pc, out_alu_op, out_rs1, out_rs2, out_rd, out_imm, out_imm_sel,
                    out_pc_alu, out_pc_cmd, out_pc_val, out_load, out_store, out_illegal};

  function automatic logic [157:0] ev(input logic [63:0] pc, input logic [4:0] op,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [4:0] rd, input logic [63:0] imm,
                                      input logic imm_sel, input logic pc_alu,
                                      input logic [1:0] pc_cmd, input logic [1:0] pc_val,
                                      input logic ld, input logic st, input logic ill);
    return {pc, op, rs1, rs2, rd, imm, imm_sel, pc_alu, pc_cmd, pc_val, ld, st, ill};
  endfunction

  task automatic chk(input string tag, input logic [157:0] obs, input logic [157:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Offer one instruction for a single cycle, then return at the following falling edge.
  task automatic push_one(input logic [31:0] instr, input logic [63:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    tick();
    in_valid = 1'b0;
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    tick(); tick(); tick();
    chk("reset_in_ready", {157'd0, in_ready}, 158'd0);
    chk("reset_out_valid", {157'd0, out_valid}, 158'd0);
    chk("reset_payload", obs_vec, 158'd0);
    reset = 1'b0;
    tick();
    chk("post_reset_in_ready", {157'd0, in_ready}, 158'd1);
    chk("post_reset_out_valid", {157'd0, out_valid}, 158'd0);

    // Streaming decode with out_ready held high
    out_ready = 1'b1;
    push_one(32'h0022_1820, 64'h40);
    chk("add_valid", {157'd0, out_valid}, 158'd1);
    chk("add", obs_vec, ev(64'h40, 5'd1, 5'd1, 5'd2, 5'd3, 64'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
    push_one(32'h2022_FFFF, 64'h44);
    chk("addi", obs_vec, ev(64'h44, 5'd1, 5'd1, 5'd2, 5'd2, ONES, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
    push_one(32'h0FFF_FFFC, 64'h100);
    chk("jal", obs_vec, ev(64'h100, 5'd15, 5'd0, 5'd0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b1, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0));
    push_one(32'hFFFF_FFFF, 64'h0);
    chk("illegal_opcode", obs_vec, ev(64'h0, 5'd0, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1));
    push_one(32'h0000_003F, 64'h0);
    chk("illegal_funct", obs_vec, ev(64'h0, 5'd0, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1));
    push_one(32'hAC22_0008, 64'h108);
    chk("sw", obs_vec, ev(64'h108, 5'd1, 5'd1, 5'd2, 5'd0, 64'd8, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
    push_one(32'h1020_FFF0, 64'h10C);
    chk("beqz", obs_vec, ev(64'h10C, 5'd16, 5'd1, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0));
    push_one(32'h3064_8001, 64'h110);
    chk("andi_zext", obs_vec, ev(64'h110, 5'd3, 5'd3, 5'd4, 5'd4, 64'h8001, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
    push_one(32'h4CA0_0000, 64'h114);
    chk("jalr", obs_vec, ev(64'h114, 5'd15, 5'd5, 5'd0, 5'd31, 64'd0, 1'b1, 1'b0, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0));
    push_one(32'h8C47_FFFC, 64'h118);
    chk("lw", obs_vec, ev(64'h118, 5'd1, 5'd2, 5'd7, 5'd7, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0));
    tick();
    chk("drained_valid", {157'd0, out_valid}, 158'd0);
    chk("drained_payload", obs_vec, 158'd0);

    // Backpressure: fill DEPTH=2, third waits, then drain in order
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0022_1820; in_pc = 64'h200;
    chk("bp_ready_empty", {157'd0, in_ready}, 158'd1);
    tick();
    chk("bp_head_a", obs_vec, ev(64'h200, 5'd1, 5'd1, 5'd2, 5'd3, 64'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
    in_instr = 32'h2022_FFFF; in_pc = 64'h204;
    chk("bp_ready_one", {157'd0, in_ready}, 158'd1);
    tick();
    chk("bp_ready_full", {157'd0, in_ready}, 158'd0);
    in_instr = 32'hAC22_0008; in_pc = 64'h208;
    tick();
    chk("bp_still_full", {157'd0, in_ready}, 158'd0);
    chk("bp_head_stable", obs_vec, ev(64'h200, 5'd1, 5'd1, 5'd2, 5'd3, 64'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
    out_ready = 1'b1;
    tick();
    chk("bp_head_b", obs_vec, ev(64'h204, 5'd1, 5'd1, 5'd2, 5'd2, ONES, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
    chk("bp_ready_after_pop", {157'd0, in_ready}, 158'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_head_c", obs_vec, ev(64'h208, 5'd1, 5'd1, 5'd2, 5'd0, 64'd8, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0));
    tick();
    chk("bp_drained", {157'd0, out_valid}, 158'd0);

    // Flush with a full FIFO and a pending input
    out_ready = 1'b0;
    push_one(32'h0022_1820, 64'h300);
    push_one(32'h2022_FFFF, 64'h304);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h0FFF_FFFC; in_pc = 64'h308;
    chk("flush_full_ready", {157'd0, in_ready}, 158'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_full_valid", {157'd0, out_valid}, 158'd0);
    chk("flush_full_payload", obs_vec, 158'd0);
    chk("flush_full_ready_back", {157'd0, in_ready}, 158'd1);
    tick();
    chk("flush_full_no_ghost", {157'd0, out_valid}, 158'd0);

    // Flush while a handshake completes: the input and the pop are both discarded
    push_one(32'h0022_1820, 64'h400);
    flush = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'hAC22_0008; in_pc = 64'h404;
    chk("flush_hs_ready", {157'd0, in_ready}, 158'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_hs_valid", {157'd0, out_valid}, 158'd0);
    tick();
    chk("flush_hs_no_ghost", {157'd0, out_valid}, 158'd0);
    push_one(32'h3064_8001, 64'h408);
    chk("post_flush_entry", obs_vec, ev(64'h408, 5'd3, 5'd3, 5'd4, 5'd4, 64'h8001, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));

    // Reset mid-burst, with flush also high to show reset wins
    out_ready = 1'b0;
    tick();
    push_one(32'h0022_1820, 64'h500);
    push_one(32'h2022_FFFF, 64'h504);
    reset = 1'b1; flush = 1'b1;
    tick();
    chk("midreset_valid", {157'd0, out_valid}, 158'd0);
    chk("midreset_ready", {157'd0, in_ready}, 158'd0);
    reset = 1'b0; flush = 1'b0;
    tick();
    chk("after_midreset_valid", {157'd0, out_valid}, 158'd0);
    chk("after_midreset_ready", {157'd0, in_ready}, 158'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
